fp_div_seq: RTL and testbench

- Sequential DLFloat16 divider: computes a / b and produces the same 20-bit unrounded intermediate format that the FPU multiplier produces. Its output feeds the shared exception/rounding stage.
- DLFloat16 format: sign a[15], exponent a[14:9] with bias 31, fraction a[8:0] with hidden leading 1.
- Mantissa quotient is formed by restoring division, one quotient bit per clock, behind a valid/ready handshake on both sides.

---
 rtl/fp_div_seq.sv | 159 +++++++++++++++
 tb/tb_fp_div_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// Sequential DLFloat16 divider producing the 20-bit unrounded {sign,exp,frac,extra,sticky} format.
// One restoring quotient bit per clock; valid/ready on both sides, result held until handoff.
module fp_div_seq #(
   parameter int BIAS  = 31,
   parameter int QBITS = 14
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [19:0] o_c
);
   localparam int CW = $clog2(QBITS);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_HOLD} state_t;

   localparam logic [1:0] SP_NONE = 2'd0;
   localparam logic [1:0] SP_ONES = 2'd1;
   localparam logic [1:0] SP_ZERO = 2'd2;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic [10:0]        r_rem;
   logic [9:0]         r_mb;
   logic [QBITS-1:0]   r_q;
   logic               r_sign;
   logic signed [7:0]  r_exp;
   logic [1:0]         r_spec;
   logic [19:0]        r_c;

   logic               w_in_ready;
   logic               w_out_valid;
   logic               w_accept;
   logic [1:0]         w_spec;
   logic signed [7:0]  w_exp_in;
   logic               w_ge;
   logic [10:0]        w_rem_sub;
   logic signed [7:0]  w_exp_n;
   logic [8:0]         w_frac;
   logic [2:0]         w_extra;
   logic               w_sticky;
   logic [19:0]        w_c_norm;

   // Specials are resolved at accept and only finalised in NORM, so c appears one edge later.
   always_comb begin
      w_spec = SP_NONE;
      if (i_a == 16'hFFFF || i_b == 16'hFFFF || i_b == 16'h0000)
         w_spec = SP_ONES;
      else if (i_a == 16'h0000)
         w_spec = SP_ZERO;
   end

   assign w_exp_in  = 8'({2'b00, i_a[14:9]}) - 8'({2'b00, i_b[14:9]}) + 8'(BIAS);
   assign w_accept  = i_in_valid & w_in_ready;

   assign w_ge      = (r_rem >= {1'b0, r_mb});
   assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (i_in_valid)
               w_state_nxt = (w_spec != SP_NONE) ? S_NORM : S_DIV;
         end
         S_DIV: begin
            if (r_cnt == '0)
               w_state_nxt = S_NORM;
         end
         S_NORM: w_state_nxt = S_HOLD;
         S_HOLD: begin
            w_out_valid = 1'b1;
            if (i_out_ready)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Quotient below 1.0 means one more fraction bit is available; exponent drops by one.
   always_comb begin
      if (r_q[QBITS-1]) begin
         w_exp_n  = r_exp;
         w_frac   = r_q[QBITS-2 -: 9];
         w_extra  = r_q[QBITS-11 -: 3];
         w_sticky = r_q[0] | (|r_rem);
      end else begin
         w_exp_n  = r_exp - 8'sd1;
         w_frac   = r_q[QBITS-3 -: 9];
         w_extra  = r_q[QBITS-12 -: 3];
         w_sticky = |r_rem;
      end
   end

   always_comb begin
      w_c_norm = {r_sign, w_exp_n[5:0], w_frac, w_extra, w_sticky};
      if (r_spec == SP_ONES)
         w_c_norm = 20'hFFFFF;
      else if (r_spec == SP_ZERO)
         w_c_norm = 20'h00000;
      else if (w_exp_n <= 8'sd0)
         w_c_norm = 20'h00000;
      else if (w_exp_n >= 8'sd63)
         w_c_norm = 20'hFFFFF;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt  <= '0;
         r_rem  <= '0;
         r_mb   <= '0;
         r_q    <= '0;
         r_sign <= 1'b0;
         r_exp  <= '0;
         r_spec <= SP_NONE;
         r_c    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt  <= CW'(QBITS - 1);
                  r_rem  <= {2'b01, i_a[8:0]};
                  r_mb   <= {1'b1, i_b[8:0]};
                  r_q    <= '0;
                  r_sign <= i_a[15] ^ i_b[15];
                  r_exp  <= w_exp_in;
                  r_spec <= w_spec;
               end
            end
            S_DIV: begin
               r_rem <= w_rem_sub << 1;
               r_q   <= {r_q[QBITS-2:0], w_ge};
               r_cnt <= r_cnt - CW'(1);
            end
            S_NORM: r_c <= w_c_norm;
            default: ;
         endcase
      end
   end

   assign o_in_ready  = w_in_ready;
   assign o_out_valid = w_out_valid;
   assign o_c         = r_c;
endmodule

// File: tb/tb_fp_div_seq.sv
// Randomised and directed bench for fp_div_seq: a queue-based scoreboard checked by an
// independent output monitor against an arithmetic reference of the division rules.
module tb_fp_div_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] c;

   typedef struct {
      logic [19:0] c;
      int          lat;
      int          acc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   last_acc = 0;
   int   last_handoff = 0;
   logic prev_ov  = 1'b0;
   logic rand_rdy = 1'b0;

   fp_div_seq dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_a         (a),
      .i_b         (b),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_c         (c)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic bit is_special(input logic [15:0] x, input logic [15:0] y);
      return (x == 16'hFFFF) || (y == 16'hFFFF) || (y == 16'h0000) || (x == 16'h0000);
   endfunction

   // Reference: whole quotient from one integer division, then the normalisation rules.
   function automatic logic [19:0] ref_div(input logic [15:0] x, input logic [15:0] y);
      longint num, q;
      int     ma, mb, e, frac, extra, sticky;
      bit     rnz;
      logic   s;
      logic [19:0] r;
      if (x == 16'hFFFF || y == 16'hFFFF) return 20'hFFFFF;
      if (y == 16'h0000) return 20'hFFFFF;
      if (x == 16'h0000) return 20'h00000;
      ma  = 512 + int'(x[8:0]);
      mb  = 512 + int'(y[8:0]);
      num = longint'(ma) * 8192;
      q   = num / mb;
      rnz = (num % mb) != 0;
      e   = int'(x[14:9]) - int'(y[14:9]) + 31;
      s   = x[15] ^ y[15];
      if (q >= 8192) begin
         frac   = int'((q / 16) % 512);
         extra  = int'((q / 2) % 8);
         sticky = int'(q % 2) | int'(rnz);
      end else begin
         frac   = int'((q / 8) % 512);
         extra  = int'(q % 8);
         sticky = int'(rnz);
         e      = e - 1;
      end
      if (e <= 0) return 20'h00000;
      if (e >= 63) return 20'hFFFFF;
      r = {s, 6'(e), 9'(frac), 3'(extra), 1'(sticky)};
      return r;
   endfunction

   task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic [19:0] expc);
      int n = 0;
      exp_t e;
      @(posedge clk); #1;
      in_valid = 1'b1; a = x; b = y;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: in_ready never rose (cycle %0d)", cyc);
            in_valid = 1'b0;
            return;
         end
      end
      e.c = expc; e.lat = is_special(x, y) ? 1 : 15; e.acc = cyc + 1;
      exp_q.push_back(e);
      last_acc = cyc + 1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         n_checks++; n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding (cycle %0d)", exp_q.size(), cyc);
         exp_q.delete();
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (out_valid && !prev_ov) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_output: c=%h with nothing outstanding (cycle %0d)", c, cyc);
            end else
               chk("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
         end
         if (out_valid && out_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("result_c", 32'(c), 32'(e.c));
            last_handoff = cyc + 1;
         end
      end
      prev_ov = out_valid;
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic [19:0] r;
   } vec_t;

   vec_t dir[9] = '{
      '{16'h4000, 16'h3E00, 20'h40000},
      '{16'hC100, 16'h3F00, 20'hC0000},
      '{16'h3E00, 16'h3F00, 20'h3CAAB},
      '{16'h3E00, 16'h0000, 20'hFFFFF},
      '{16'h0000, 16'h3E00, 20'h00000},
      '{16'hFFFF, 16'h0000, 20'hFFFFF},
      '{16'h7C00, 16'h3E00, 20'h7C000},
      '{16'h7C00, 16'h3C00, 20'hFFFFF},
      '{16'h3E00, 16'h7B00, 20'h00000}
   };

   initial begin
      int acc;
      int n;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_c", 32'(c), 32'd0);

      foreach (dir[i]) begin
         issue(dir[i].x, dir[i].y, dir[i].r);
         drain();
      end

      // Backpressure: result held while a second operand waits at the input.
      out_ready = 1'b0;
      issue(16'h4000, 16'h3E00, 20'h40000);
      fork
         issue(16'hC100, 16'h3F00, 20'hC0000);
         begin
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!out_valid && n < 40);
            for (int k = 0; k < 5; k++) begin
               if (k > 0) @(negedge clk);
               chk("bp_c_stable", 32'(c), 32'h40000);
               chk("bp_in_ready", 32'(in_ready), 32'd0);
               chk("bp_out_valid", 32'(out_valid), 32'd1);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      chk("bp_accept_after_handoff", 32'(last_acc), 32'(last_handoff + 1));
      drain();

      // Reset pulse landing on DIV edge 7.
      issue(16'h3E00, 16'h3F00, 20'h3CAAB);
      acc = last_acc;
      while (cyc < acc + 6) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_c", 32'(c), 32'd0);
      repeat (25) @(negedge clk);
      issue(16'h4000, 16'h3E00, 20'h40000);
      drain();

      rand_rdy = 1'b1;
      for (int i = 0; i < 60; i++) begin
         logic [15:0] x, y;
         int sel;
         x = 16'($urandom); y = 16'($urandom);
         sel = $urandom_range(0, 9);
         if (sel == 0) x = 16'h0000;
         else if (sel == 1) y = 16'h0000;
         else if (sel == 2) x = 16'hFFFF;
         issue(x, y, ref_div(x, y));
         drain();
      end
      rand_rdy = 1'b0;
      @(posedge clk); #2;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
